// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared definitions for the load/store unit: memory op codes, FSM states and
// request classification helpers.
package ysyx_25030081_lsu_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Stores only know B/H/W; loads additionally know the unsigned variants.
    function automatic logic op_is_legal(input logic wr, input logic [2:0] op);
        logic ok;
        case (op)
            MEM_OP_B, MEM_OP_H, MEM_OP_W: ok = 1'b1;
            MEM_OP_BU, MEM_OP_HU:         ok = ~wr;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] a_lo);
        logic mis;
        case (op[1:0])
            2'b01:   mis = a_lo[0];
            2'b10:   mis = (a_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement and load
// byte/half extraction with sign or zero extension.
module ysyx_25030081_lsu_align
    import ysyx_25030081_lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Place store data on the lanes selected by size and address.
    always_comb begin
        o_st_wdata = 32'h0000_0000;
        o_st_wstrb = 4'b0000;
        case (i_st_size)
            2'b00: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_addr_lo;
            end
            2'b01: begin
                if (i_st_addr_lo[1]) begin
                    o_st_wdata = {i_st_data[15:0], 16'h0000};
                    o_st_wstrb = 4'b1100;
                end else begin
                    o_st_wdata = {16'h0000, i_st_data[15:0]};
                    o_st_wstrb = 4'b0011;
                end
            end
            2'b10: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
            default: begin
                o_st_wdata = 32'h0000_0000;
                o_st_wstrb = 4'b0000;
            end
        endcase
    end

    // Pick the addressed byte and half-word out of the bus word.
    always_comb begin
        w_ld_byte = 8'h00;
        case (i_ld_addr_lo)
            2'b00:   w_ld_byte = i_ld_rdata[7:0];
            2'b01:   w_ld_byte = i_ld_rdata[15:8];
            2'b10:   w_ld_byte = i_ld_rdata[23:16];
            2'b11:   w_ld_byte = i_ld_rdata[31:24];
            default: w_ld_byte = 8'h00;
        endcase
        if (i_ld_addr_lo[1]) begin
            w_ld_half = i_ld_rdata[31:16];
        end else begin
            w_ld_half = i_ld_rdata[15:0];
        end
    end

    // Extend the selected field according to the load op.
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_op)
            MEM_OP_B:  o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            MEM_OP_H:  o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            MEM_OP_W:  o_ld_data = i_ld_rdata;
            MEM_OP_BU: o_ld_data = {24'h000000, w_ld_byte};
            MEM_OP_HU: o_ld_data = {16'h0000, w_ld_half};
            default:   o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: accepts one core request at a time, drives a valid/ready
// data-bus access, waits for completion with a timeout and returns a single
// response pulse.
// Optional build macro YSYX_25030081_LSU_MISALIGN_CHECK_EN: when defined,
// misaligned H/HU/W accesses are answered with an error and never reach the bus.
module ysyx_25030081_lsu
    import ysyx_25030081_lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [2:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    lsu_state_e        r_state, w_state_nxt;
    logic              r_wr, w_wr_nxt;
    logic [2:0]        r_op, w_op_nxt;
    logic [1:0]        r_addr_lo, w_addr_lo_nxt;
    logic [7:0]        r_tmo_cnt, w_tmo_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic              r_mem_valid, w_mem_valid_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]        r_mem_wstrb, w_mem_wstrb_nxt;

    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_ld_data;
    logic              w_misalign;
    logic              w_reject;

    // Store lanes come from the live request; load extraction uses the latched op.
    ysyx_25030081_lsu_align u_align (
        .i_st_size    (i_req_op[1:0]),
        .i_st_addr_lo (i_req_addr[1:0]),
        .i_st_data    (i_req_wdata),
        .i_ld_op      (r_op),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_rdata   (i_mem_rdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_wstrb   (w_st_wstrb),
        .o_ld_data    (w_ld_data)
    );

`ifdef YSYX_25030081_LSU_MISALIGN_CHECK_EN
    assign w_misalign = op_is_misaligned(i_req_op, i_req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Requests that are answered immediately with an error, without bus traffic.
    assign w_reject = ~op_is_legal(i_req_wr, i_req_op) | w_misalign;

    // Next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_nxt        = r_wr;
        w_op_nxt        = r_op;
        w_addr_lo_nxt   = r_addr_lo;
        w_tmo_nxt       = r_tmo_cnt;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_wr_nxt      = i_req_wr;
                    w_op_nxt      = i_req_op;
                    w_addr_lo_nxt = i_req_addr[1:0];
                    w_tmo_nxt     = 8'd0;
                    if (w_reject) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = 32'h0000_0000;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ST_REQ;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_we_nxt    = i_req_wr;
                        w_mem_addr_nxt  = {i_req_addr[ADDR_W-1:2], 2'b00};
                        w_mem_wdata_nxt = i_req_wr ? w_st_wdata : 32'h0000_0000;
                        w_mem_wstrb_nxt = i_req_wr ? w_st_wstrb : 4'b0000;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_mem_ready) begin
                    w_state_nxt     = ST_WAIT;
                    w_tmo_nxt       = 8'd0;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = {ADDR_W{1'b0}};
                    w_mem_wdata_nxt = 32'h0000_0000;
                    w_mem_wstrb_nxt = 4'b0000;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_nxt     = ST_RESP;
                    w_tmo_nxt       = 8'd0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_wr ? 32'h0000_0000 : w_ld_data;
                    w_rsp_err_nxt   = 1'b0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt     = ST_RESP;
                    w_tmo_nxt       = 8'd0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'h0000_0000;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 8'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_mem_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, payload and output registers; reset drops any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_op        <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_tmo_cnt   <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= 32'h0000_0000;
            r_mem_wstrb <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_wr        <= w_wr_nxt;
            r_op        <= w_op_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wstrb = r_mem_wstrb;

endmodule
